johnson_decoder: RTL and testbench
==================================

# johnson_decoder

Receive-side companion to the twisted-ring (Johnson) counter: samples an 8-bit Johnson code word, checks it is one of the 16 legal states, and decodes it to a 4-bit phase index. It also checks that consecutive samples advance by exactly one step, runs a lock state machine, and keeps a saturating error count. It sits downstream of any Johnson-coded source, such as a ring counter, a clock-phase tap bus or an encoder position track, and gives the control logic a binary phase plus a health status.

## Interface
- SIZE, 7: MSB index of the code bus; code width is SIZE+1 = 8 and phase count is 2*(SIZE+1) = 16. Only the default needs to be supported; the RTL must stay parameter-clean.
- LOCK_CNT, 4: consecutive legal, in-step samples required to assert locked (range 2..15).
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  system clock, rising edge.
- r  in  1  reset. Synchronous, active-high; it wins over every other input.
- in_valid  in  1  qualifies code for this cycle.
- code  in  [0:SIZE]  Johnson word. code[0] is the bit the source shifts ~code[SIZE] into.
- phase  out  4  decoded phase index 0..15.
- phase_valid  out  1  one-cycle pulse: phase/legal/step_ok reflect a new sample.
- legal  out  1  the sample was a legal Johnson word.
- step_ok  out  1  the sample is legal and its phase equals the previous legal phase +1 mod 16.
- wrap  out  1  one-cycle pulse when a step_ok sample moves the phase from 15 to 0.
- locked  out  1  lock FSM is in LOCKED.
- err_cnt  out  ERR_W  saturating count of errors.

## Operation
- Legal words, with bit order written code[0]..code[SIZE]:
  - phase k, 0≤k≤8: code[0..k-1]=1 and all other bits 0. Phase 0 = 0000_0000; phase 8 = 1111_1111.
  - phase k, 9≤k≤15: code[0..k-9]=0 and all other bits 1. Phase 9 = 0111_1111; phase 15 = 0000_0001.
  - The other 240 words are illegal.
- Decode:
  - If code[SIZE]=0, phase = number of leading ones from code[0].
  - Otherwise, phase = 8 + number of leading zeros from code[0].
  - Legality is checked by exact comparison against the reconstructed word.
- Internal state:
  - prev_phase (4b) and prev_ok (1b). prev_ok is set by any legal sample and cleared by an illegal sample or reset.
  - run counter (4b).
  - FSM state.
- Only cycles with in_valid=1 change internal state. Cycles with in_valid=0 hold everything; phase_valid, wrap=0.
- FSM states, per valid sample:
  - UNLOCKED:
    - legal → ACQUIRE, run=1.
    - illegal → stay, err_cnt+1.
  - ACQUIRE:
    - step_ok → run+1; when run+1 = LOCK_CNT → LOCKED.
    - legal but not in step → stay, run=1, err_cnt+1.
    - illegal → UNLOCKED, err_cnt+1.
  - LOCKED:
    - step_ok → stay.
    - legal but not in step → ACQUIRE, run=1, err_cnt+1.
    - illegal → UNLOCKED, err_cnt+1.
- err_cnt saturates at 2^ERR_W-1 and never wraps. It is cleared only by r.
- An illegal sample leaves phase at its last legal value and forces legal=0, step_ok=0.

## Timing
- All outputs are registered. Latency is 1 cycle: a sample presented at edge n is reflected after edge n+1. That covers phase, legal, step_ok, wrap, phase_valid, the locked transition and the err_cnt increment.
- Reset values (after the first edge with r=1): phase=0, phase_valid=0, legal=0, step_ok=0, wrap=0, locked=0, err_cnt=0, FSM=UNLOCKED, prev_ok=0, run=0.
- Reset mid-operation: a valid sample in the same cycle as r=1 is discarded. The first post-reset sample is never step_ok, since prev_ok=0.
- Back-to-back samples (in_valid held high) are accepted every cycle with no bubbles.
- Gaps in in_valid are not errors. Continuity is judged between consecutive valid samples only.
- Repeating the same legal phase is a step error.

## Test plan
- Sync reset, then feed phases 0..15,0 continuously from 0000_0000.
  - Expected: phase tracks 0..15,0.
  - legal=1 throughout; step_ok=0 on the first sample, 1 after.
  - locked=1 one cycle after the 4th sample (phase 3).
  - wrap pulses once, on the 15→0 sample; err_cnt=0.
- While LOCKED, inject 0101_0101.
  - Expected: legal=0, locked=0, err_cnt=1, phase holds its last value.
  - Follow with a legal word: FSM goes to ACQUIRE and step_ok=0 for that word.
- While LOCKED at phase 3 (1110_0000), send 1111_1000 (phase 5).
  - Expected: legal=1, step_ok=0, locked drops, err_cnt+1.
  - Then phases 6,7,8 relock after the phase-8 sample.
- Lock, then apply r=1 for one cycle together with in_valid=1.
  - Expected: all outputs return to their reset values next cycle and the sample is ignored.
- Insert random in_valid=0 gaps (1-5 cycles) into a legal ascending sequence.
  - Expected: lock holds, phase_valid only on valid cycles, err_cnt stays 0.
- Drive 300 illegal samples with ERR_W=8.
  - Expected: err_cnt reaches 255 and stays 255.

Source files
------------

// File: rtl/johnson_decoder.sv
`default_nettype none
// ============================================================================
// Module   : johnson_decoder
// Brief    : Decodes/validates a Johnson code word, tracks step continuity,
//            runs a lock FSM and keeps a saturating error count.
// Revision : 1.0
// ============================================================================
module johnson_decoder #(
    parameter int SIZE     = 7,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic                            clk,
    input  logic                            r,
    input  logic                            in_valid,
    input  logic [0:SIZE]                   code,
    output logic [$clog2(2*(SIZE+1))-1:0]   phase,
    output logic                            phase_valid,
    output logic                            legal,
    output logic                            step_ok,
    output logic                            wrap,
    output logic                            locked,
    output logic [ERR_W-1:0]                err_cnt
);

    localparam int N  = SIZE + 1;
    localparam int PW = $clog2(2 * N);
    localparam int CW = $clog2(N + 1);
    localparam int RW = 4;

    localparam logic [PW-1:0]    C_PH_ONE   = PW'(1);
    localparam logic [PW-1:0]    C_PH_LAST  = PW'(2 * N - 1);
    localparam logic [PW-1:0]    C_PH_HALF  = PW'(N);
    localparam logic [CW-1:0]    C_LEAD_ONE = CW'(1);
    localparam logic [RW-1:0]    C_RUN_ONE  = RW'(1);
    localparam logic [RW-1:0]    C_RUN_LOCK = RW'(LOCK_CNT);
    localparam logic [ERR_W-1:0] C_ERR_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0] C_ERR_MAX  = '1;

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_ACQUIRE  = 2'd1,
        S_LOCKED   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic              phase_valid_q, phase_valid_d;
    logic              legal_q, legal_d;
    logic              step_ok_q, step_ok_d;
    logic              wrap_q, wrap_d;
    logic              locked_q, locked_d;
    logic              prev_ok_q, prev_ok_d;
    logic [RW-1:0]     run_q, run_d;
    logic [ERR_W-1:0]  err_q, err_d;

    logic [CW-1:0]     w_lead;
    logic              w_stop;
    logic [0:SIZE]     w_recon;
    logic              w_legal;
    logic [PW-1:0]     w_phase;
    logic [PW-1:0]     w_expect;
    logic              w_step;
    logic              w_wrap;
    logic              w_err_inc;

    // Run length of bits matching code[0]'s expected polarity, then rebuild
    // the only legal word with that run to test legality exactly.
    always_comb begin
        w_lead = '0;
        w_stop = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (!w_stop && (code[i] != code[SIZE])) begin
                w_lead = w_lead + C_LEAD_ONE;
            end else begin
                w_stop = 1'b1;
            end
        end
        for (int i = 0; i <= SIZE; i++) begin
            w_recon[i] = code[SIZE] ^ (i < int'(w_lead));
        end
    end

    assign w_legal  = (w_recon == code);
    assign w_phase  = code[SIZE] ? (C_PH_HALF + PW'(w_lead)) : PW'(w_lead);
    // phase_q always holds the last legal phase, so it doubles as prev_phase.
    assign w_expect = (phase_q == C_PH_LAST) ? '0 : (phase_q + C_PH_ONE);
    assign w_step   = w_legal && prev_ok_q && (w_phase == w_expect);
    assign w_wrap   = w_step && (phase_q == C_PH_LAST);

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        phase_valid_d = 1'b0;
        legal_d       = legal_q;
        step_ok_d     = step_ok_q;
        wrap_d        = 1'b0;
        prev_ok_d     = prev_ok_q;
        run_d         = run_q;
        err_d         = err_q;
        w_err_inc     = 1'b0;

        if (in_valid) begin
            phase_valid_d = 1'b1;
            legal_d       = w_legal;
            step_ok_d     = w_step;
            wrap_d        = w_wrap;
            prev_ok_d     = w_legal;
            if (w_legal) begin
                phase_d = w_phase;
            end

            case (state_q)
                S_UNLOCKED: begin
                    if (w_legal) begin
                        state_d = S_ACQUIRE;
                        run_d   = C_RUN_ONE;
                    end else begin
                        w_err_inc = 1'b1;
                    end
                end
                S_ACQUIRE: begin
                    if (w_step) begin
                        run_d = run_q + C_RUN_ONE;
                        if (run_d == C_RUN_LOCK) begin
                            state_d = S_LOCKED;
                        end
                    end else if (w_legal) begin
                        run_d     = C_RUN_ONE;
                        w_err_inc = 1'b1;
                    end else begin
                        state_d   = S_UNLOCKED;
                        run_d     = '0;
                        w_err_inc = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (!w_step) begin
                        w_err_inc = 1'b1;
                        if (w_legal) begin
                            state_d = S_ACQUIRE;
                            run_d   = C_RUN_ONE;
                        end else begin
                            state_d = S_UNLOCKED;
                            run_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = S_UNLOCKED;
                    run_d   = '0;
                end
            endcase
        end

        if (w_err_inc && (err_q != C_ERR_MAX)) begin
            err_d = err_q + C_ERR_ONE;
        end
        locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q       <= S_UNLOCKED;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            legal_q       <= 1'b0;
            step_ok_q     <= 1'b0;
            wrap_q        <= 1'b0;
            locked_q      <= 1'b0;
            prev_ok_q     <= 1'b0;
            run_q         <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            legal_q       <= legal_d;
            step_ok_q     <= step_ok_d;
            wrap_q        <= wrap_d;
            locked_q      <= locked_d;
            prev_ok_q     <= prev_ok_d;
            run_q         <= run_d;
            err_q         <= err_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign legal       = legal_q;
    assign step_ok     = step_ok_q;
    assign wrap        = wrap_q;
    assign locked      = locked_q;
    assign err_cnt     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_johnson_decoder
// Brief    : Directed plus randomized bench for johnson_decoder against a
//            table-driven reference model.
// Revision : 1.0
// ============================================================================
module tb_johnson_decoder;

    localparam int SIZE     = 7;
    localparam int N        = SIZE + 1;
    localparam int NPH      = 2 * N;
    localparam int LOCK_CNT = 4;
    localparam int ERR_W    = 8;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              r;
    logic              in_valid;
    logic [0:SIZE]     code;
    logic [3:0]        phase;
    logic              phase_valid;
    logic              legal;
    logic              step_ok;
    logic              wrap;
    logic              locked;
    logic [ERR_W-1:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int wrap_seen = 0;

    // Reference model: mode 0=unlocked, 1=acquiring, 2=locked
    int  m_mode, m_run, m_err, m_phase;
    bit  m_prev_ok, m_legal, m_step, m_wrap, m_pv;
    logic [0:SIZE] tab [NPH];

    johnson_decoder #(.SIZE(SIZE), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk         (clk),
        .r           (r),
        .in_valid    (in_valid),
        .code        (code),
        .phase       (phase),
        .phase_valid (phase_valid),
        .legal       (legal),
        .step_ok     (step_ok),
        .wrap        (wrap),
        .locked      (locked),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int lookup(input logic [0:SIZE] w);
        for (int k = 0; k < NPH; k++) begin
            if (tab[k] === w) return k;
        end
        return -1;
    endfunction

    task automatic model(input bit rst, input bit v, input logic [0:SIZE] w);
        int idx;
        if (rst) begin
            m_mode = 0; m_run = 0; m_err = 0; m_phase = 0;
            m_prev_ok = 0; m_legal = 0; m_step = 0; m_wrap = 0; m_pv = 0;
            return;
        end
        m_pv = v;
        m_wrap = 0;
        if (!v) return;
        idx = lookup(w);
        if (idx < 0) begin
            m_legal = 0;
            m_step = 0;
            m_prev_ok = 0;
            if (m_err < ERR_MAX) m_err++;
            m_mode = 0;
            m_run = 0;
        end else begin
            m_step = m_prev_ok && (idx == (m_phase + 1) % NPH);
            m_wrap = m_step && (idx == 0);
            m_legal = 1;
            if (m_mode == 0) begin
                m_mode = 1;
                m_run = 1;
            end else if (!m_step) begin
                m_mode = 1;
                m_run = 1;
                if (m_err < ERR_MAX) m_err++;
            end else if (m_mode == 1) begin
                m_run++;
                if (m_run == LOCK_CNT) m_mode = 2;
            end
            m_phase = idx;
            m_prev_ok = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input string tag, input bit rst, input bit v, input logic [0:SIZE] w);
        r        = rst;
        in_valid = v;
        code     = w;
        model(rst, v, w);
        @(posedge clk);
        #1;
        if (wrap === 1'b1) wrap_seen++;
        chk({tag, ".phase"},       32'(phase),       32'(m_phase));
        chk({tag, ".phase_valid"}, 32'(phase_valid), 32'(m_pv));
        chk({tag, ".legal"},       32'(legal),       32'(m_legal));
        chk({tag, ".step_ok"},     32'(step_ok),     32'(m_step));
        chk({tag, ".wrap"},        32'(wrap),        32'(m_wrap));
        chk({tag, ".locked"},      32'(locked),      32'(m_mode == 2));
        chk({tag, ".err_cnt"},     32'(err_cnt),     32'(m_err));
    endtask

    initial begin
        logic [0:SIZE] w;
        int sel;
        int p;

        for (int k = 0; k < NPH; k++) begin
            for (int i = 0; i <= SIZE; i++) begin
                tab[k][i] = (k <= N) ? (i < k) : (i >= k - N);
            end
        end

        r = 1'b1;
        in_valid = 1'b0;
        code = '0;

        drive("reset", 1, 0, '0);
        drive("reset", 1, 0, '0);

        // Ascending 0..15,0 from reset
        wrap_seen = 0;
        for (int k = 0; k <= NPH; k++) drive("ascend", 0, 1, tab[k % NPH]);
        chk("ascend.wrap_once", 32'(wrap_seen), 32'd1);
        chk("ascend.locked_end", 32'(locked), 32'd1);
        chk("ascend.phase_end", 32'(phase), 32'd0);

        // Illegal word while locked, then a legal word
        drive("illegal", 0, 1, 8'b0101_0101);
        chk("illegal.err1", 32'(err_cnt), 32'd1);
        chk("illegal.hold", 32'(phase), 32'd0);
        drive("after_ill", 0, 1, tab[1]);

        // Relock, reach phase 3, then skip to 5 and relock on 6,7,8
        for (int k = 2; k <= 19; k++) drive("relock", 0, 1, tab[k % NPH]);
        chk("relock.locked_at3", 32'(locked), 32'd1);
        chk("relock.code3", 32'(tab[3]), 32'(8'b1110_0000));
        drive("skip", 0, 1, 8'b1111_1000);
        chk("skip.step_ok", 32'(step_ok), 32'd0);
        chk("skip.unlocked", 32'(locked), 32'd0);
        for (int k = 6; k <= 8; k++) drive("skip_relock", 0, 1, tab[k]);
        chk("skip.relocked", 32'(locked), 32'd1);

        // Reset coinciding with a valid sample
        drive("rst_valid", 1, 1, tab[9]);
        chk("rst_valid.err", 32'(err_cnt), 32'd0);
        chk("rst_valid.phase", 32'(phase), 32'd0);
        drive("post_rst", 0, 1, tab[10]);

        // Ascending with random in_valid gaps; invalid cycles carry junk
        p = 11;
        for (int n = 0; n < 40; n++) begin
            drive("gap", 0, 1, tab[p % NPH]);
            p++;
            if ($urandom_range(0, 1) == 1) begin
                sel = $urandom_range(1, 5);
                for (int g = 0; g < sel; g++) drive("gap_idle", 0, 0, 8'($urandom));
            end
        end
        chk("gap.locked", 32'(locked), 32'd1);
        chk("gap.err", 32'(err_cnt), 32'd0);

        // Random mix of in-step, jumping, junk and idle samples
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 50)      drive("mix_next", 0, 1, tab[(m_phase + 1) % NPH]);
            else if (sel < 65) drive("mix_jump", 0, 1, tab[$urandom_range(0, NPH - 1)]);
            else if (sel < 85) drive("mix_junk", 0, 1, 8'($urandom));
            else               drive("mix_idle", 0, 0, 8'($urandom));
        end

        // Saturation
        for (int n = 0; n < 300; n++) begin
            do w = 8'($urandom); while (lookup(w) >= 0);
            drive("sat", 0, 1, w);
        end
        chk("sat.max", 32'(err_cnt), 32'd255);
        drive("sat_legal", 0, 1, tab[4]);
        drive("sat_ill", 0, 1, 8'b1010_1010);
        chk("sat.hold", 32'(err_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
